// File: rtl/seg_sched.sv
// seg_sched: arbitrates time-core and editor frame updates plus blink refreshes,
// and drives the write/write/readback sequence on seg_show's register port.
module seg_sched #(
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 t_valid,
  output logic                 t_ready,
  input  logic [15:0]          t_digits,
  input  logic [3:0]           t_dp,
  input  logic [7:0]           t_led,
  input  logic                 e_valid,
  output logic                 e_ready,
  input  logic [31:0]          e_frame,
  input  logic [7:0]           e_led,
  input  logic [3:0]           blink_mask,
  input  logic                 err_clr,
  output logic                 wr,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 rd,
  output logic [ADDRWIDTH-1:0] raddr,
  input  logic [31:0]          rdata,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ADDRWIDTH-1:0] AddrScan   = ADDRWIDTH'(4);
  localparam logic [ADDRWIDTH-1:0] AddrStatic = ADDRWIDTH'(8);
  localparam logic [CntW-1:0]      CntLast    = CntW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StWrScan, StWrStatic, StRd, StCheck} state_e;

  state_e          state_q, state_d;
  logic            ptr_q;          // 0: time core preferred, 1: editor preferred
  logic [CntW-1:0] cnt_q;
  logic            phase_q;        // 1: digits shown, 0: blinking digits blanked
  logic            pend_q;
  logic            have_q;
  logic [31:0]     last_frame_q;
  logic [7:0]      last_led_q;
  logic [31:0]     scan_q;         // blanked scan word of the running transaction
  logic            err_q;

  logic            gnt_ref, gnt_t, gnt_e, gnt_any;
  logic [31:0]     src_frame, capt_frame;
  logic [7:0]      src_led;
  logic            wrap, mismatch;

  // Time-core digits to seg_show byte format: on, dp, no dash, hex value.
  function automatic logic [31:0] t_to_frame(input logic [15:0] d, input logic [3:0] dp);
    logic [31:0] f;
    for (int i = 0; i < 4; i++) begin
      f[8*i +: 8] = {1'b1, dp[i], 2'b00, d[4*i +: 4]};
    end
    return f;
  endfunction

  // Blank masked digits while the blink phase is off.
  function automatic logic [31:0] blank(input logic [31:0] f, input logic [3:0] mask,
                                        input logic phase);
    logic [31:0] r;
    r = f;
    for (int i = 0; i < 4; i++) begin
      if (!phase && mask[i]) r[8*i +: 8] = 8'h00;
    end
    return r;
  endfunction

  // Arbitration: refresh first, then round-robin between time core and editor.
  always_comb begin
    gnt_ref = 1'b0;
    gnt_t   = 1'b0;
    gnt_e   = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (pend_q) begin
        gnt_ref = 1'b1;
      end else if (t_valid && e_valid) begin
        gnt_t = ~ptr_q;
        gnt_e = ptr_q;
      end else begin
        gnt_t = t_valid;
        gnt_e = e_valid;
      end
    end
    gnt_any = gnt_ref | gnt_t | gnt_e;
  end

  // Payload selection for the frame captured at grant.
  always_comb begin
    src_frame  = gnt_e ? e_frame : t_to_frame(t_digits, t_dp);
    src_led    = gnt_e ? e_led : t_led;
    capt_frame = gnt_ref ? last_frame_q : src_frame;
  end

  // Next-state logic and bus strobes; everything is zero outside the write/read states.
  always_comb begin
    state_d = state_q;
    t_ready = gnt_t;
    e_ready = gnt_e;
    wr      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    rd      = 1'b0;
    raddr   = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) state_d = StWrScan;
      end
      StWrScan: begin
        wr      = 1'b1;
        waddr   = AddrScan;
        wdata   = scan_q;
        state_d = StWrStatic;
      end
      StWrStatic: begin
        wr      = 1'b1;
        waddr   = AddrStatic;
        wdata   = {24'h0, last_led_q};
        state_d = StRd;
      end
      StRd: begin
        rd      = 1'b1;
        raddr   = AddrScan;
        state_d = StCheck;
      end
      StCheck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign err      = err_q;
  assign wrap     = (cnt_q == CntLast);
  assign mismatch = (state_q == StCheck) && (rdata != scan_q);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Payload capture at grant; last_* keep the unblanked source for refreshes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= 1'b0;
      have_q       <= 1'b0;
      last_frame_q <= '0;
      last_led_q   <= '0;
      scan_q       <= '0;
    end else if (gnt_any) begin
      scan_q <= blank(capt_frame, blink_mask, phase_q);
      if (!gnt_ref) begin
        ptr_q        <= gnt_t;
        have_q       <= 1'b1;
        last_frame_q <= src_frame;
        last_led_q   <= src_led;
      end
    end
  end

  // Blink timebase; a toggle while a refresh is being granted re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) phase_q <= ~phase_q;
      if (wrap && have_q) pend_q <= 1'b1;
      else if (gnt_ref)   pend_q <= 1'b0;
    end
  end

  // Sticky readback error; a mismatch beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_q <= 1'b0;
    else if (mismatch) err_q <= 1'b1;
    else if (err_clr)  err_q <= 1'b0;
  end

endmodule

// File: tb/tb_seg_sched.sv
// Testbench for seg_sched: transaction-level reference model, vector table,
// directed multi-cycle sequences and randomized traffic.
module tb_seg_sched;
  localparam int unsigned AW = 4;
  localparam int unsigned BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic t_valid, t_ready, e_valid, e_ready;
  logic [15:0] t_digits;
  logic [3:0] t_dp, blink_mask;
  logic [7:0] t_led, e_led;
  logic [31:0] e_frame, wdata, rdata;
  logic err_clr, wr, rd, busy, err;
  logic [AW-1:0] waddr, raddr;

  seg_sched #(.ADDRWIDTH(AW), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .t_valid(t_valid), .t_ready(t_ready), .t_digits(t_digits),
    .t_dp(t_dp), .t_led(t_led), .e_valid(e_valid), .e_ready(e_ready), .e_frame(e_frame),
    .e_led(e_led), .blink_mask(blink_mask), .err_clr(err_clr), .wr(wr), .waddr(waddr),
    .wdata(wdata), .rd(rd), .raddr(raddr), .rdata(rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: a transaction is a 4-step timeline started at grant.
  int          m_age;
  int          m_cnt;
  bit          m_phase, m_pend, m_have, m_ptr_e, m_err;
  logic [31:0] m_last_frame, m_scan;
  logic [7:0]  m_last_led, m_led;

  // seg_show stand-in
  logic [31:0] shadow_scan;
  bit          corrupt;

  // Observations from the most recent tick
  bit          obs_tr, obs_er, obs_wr;
  logic [AW-1:0] obs_waddr;
  logic [31:0] obs_wdata;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [7:0]  led;
    logic [31:0] exp_scan;
  } vec_t;

  function automatic logic [31:0] mk_frame(input logic [15:0] d, input logic [3:0] dp);
    logic [31:0] f;
    for (int i = 0; i < 4; i++) f[8*i +: 8] = {1'b1, dp[i], 2'b00, d[4*i +: 4]};
    return f;
  endfunction

  function automatic logic [31:0] mk_blank(input logic [31:0] f, input logic [3:0] m,
                                           input bit ph);
    logic [31:0] r;
    r = f;
    if (!ph) for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at cycle %0d: timed out, got no event, expected one", name, cyc);
  endtask

  task automatic model_reset();
    m_age = 0; m_cnt = 0; m_phase = 1; m_pend = 0; m_have = 0; m_ptr_e = 0; m_err = 0;
    m_last_frame = '0; m_last_led = '0; m_scan = '0; m_led = '0;
    shadow_scan = '0; cyc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    t_valid = 0; e_valid = 0; t_digits = '0; t_dp = '0; t_led = '0;
    e_frame = '0; e_led = '0; blink_mask = '0; err_clr = 0; corrupt = 0; rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: inputs are already set; compare outputs, advance the model.
  task automatic tick();
    bit g_ref, g_t, g_e, mism, have_old;
    logic [31:0] src;
    rdata = corrupt ? 32'hDEADBEEF : shadow_scan;
    #2;
    g_ref = 0; g_t = 0; g_e = 0;
    if (m_age == 0) begin
      if (m_pend) g_ref = 1;
      else if (t_valid && e_valid) begin g_t = !m_ptr_e; g_e = m_ptr_e; end
      else begin g_t = t_valid; g_e = e_valid; end
    end
    chk("t_ready", t_ready, g_t);
    chk("e_ready", e_ready, g_e);
    chk("wr", wr, (m_age == 1 || m_age == 2));
    chk("waddr", waddr, (m_age == 1) ? 4 : (m_age == 2) ? 8 : 0);
    chk("wdata", wdata, (m_age == 1) ? m_scan : (m_age == 2) ? {24'h0, m_led} : 32'h0);
    chk("rd", rd, m_age == 3);
    chk("raddr", raddr, (m_age == 3) ? 4 : 0);
    chk("busy", busy, m_age != 0);
    chk("err", err, m_err);
    obs_tr = t_ready; obs_er = e_ready; obs_wr = wr; obs_waddr = waddr; obs_wdata = wdata;
    if (wr && waddr == 4) shadow_scan = wdata;
    // model update
    mism = (m_age == 4) && (rdata != m_scan);
    m_err = mism ? 1 : (err_clr ? 0 : m_err);
    have_old = m_have;
    if (g_ref) begin
      m_scan = mk_blank(m_last_frame, blink_mask, m_phase);
      m_led = m_last_led; m_pend = 0; m_age = 1;
    end else if (g_t || g_e) begin
      src = g_e ? e_frame : mk_frame(t_digits, t_dp);
      m_last_frame = src;
      m_last_led = g_e ? e_led : t_led;
      m_scan = mk_blank(src, blink_mask, m_phase);
      m_led = m_last_led; m_ptr_e = g_t; m_have = 1; m_age = 1;
    end else if (m_age != 0) begin
      m_age = (m_age == 4) ? 0 : m_age + 1;
    end
    if (m_cnt == BD - 1) begin
      m_cnt = 0; m_phase = !m_phase;
      if (have_old) m_pend = 1;
    end else m_cnt++;
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic wait_t_grant(input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_tr) begin t_valid = 0; return; end
    end
    t_valid = 0;
    expire(name);
  endtask

  vec_t vecs[5];
  int   src_q[$];
  int   gcyc_q[$];
  logic [31:0] ref_q[$];
  int   cnt_ready, cnt_bus;

  initial begin
    vecs[0] = '{16'h1234, 4'b0100, 8'hA5, 32'h81C28384};
    vecs[1] = '{16'h0000, 4'b0000, 8'h00, 32'h80808080};
    vecs[2] = '{16'h9876, 4'b1111, 8'hFF, 32'hC9C8C7C6};
    vecs[3] = '{16'hABCD, 4'b1010, 8'h3C, 32'hCA8BCC8D};
    vecs[4] = '{16'h5050, 4'b0001, 8'h01, 32'h858085C0};

    // Reset values
    do_reset();
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_wr_wdata", {wr, rd, waddr, raddr, t_ready, e_ready, err}, 0);
    chk("reset_wdata", wdata, 0);

    // First frame: ready in the very first cycle, full bus sequence
    t_digits = 16'h1234; t_dp = 4'b0100; t_led = 8'hA5; t_valid = 1;
    tick();
    chk("first_t_ready", obs_tr, 1);
    t_valid = 0;
    tick(); chk("first_scan", {obs_wr, 28'(obs_waddr)}, {1'b1, 28'h4});
    chk("first_scan_data", obs_wdata, 32'h81C28384);
    tick(); chk("first_static_data", obs_wdata, 32'h000000A5);
    tick(); tick(); tick();
    chk("first_idle_err", {busy, err}, 0);

    // Vector table: time-core encoding
    for (int v = 0; v < 5; v++) begin
      blink_mask = 0;
      t_digits = vecs[v].d; t_dp = vecs[v].dp; t_led = vecs[v].led; t_valid = 1;
      wait_t_grant("vec_grant");
      tick(); chk("vec_scan", obs_wdata, vecs[v].exp_scan);
      tick(); chk("vec_static", obs_wdata, {24'h0, vecs[v].led});
      repeat (2) tick();
    end

    // Editor frame is used verbatim
    do_reset();
    e_frame = 32'h12F0A55A; e_led = 8'h3E; e_valid = 1;
    tick(); chk("e_ready", obs_er, 1);
    e_valid = 0;
    tick(); chk("e_scan", obs_wdata, 32'h12F0A55A);
    tick(); chk("e_static", obs_wdata, 32'h0000003E);
    repeat (3) tick();

    // Round-robin with both requesters held
    do_reset();
    t_digits = 16'h0001; e_frame = 32'h01020304; t_valid = 1; e_valid = 1;
    for (int i = 0; i < 80 && src_q.size() < 6; i++) begin
      tick();
      if (obs_tr) begin src_q.push_back(0); gcyc_q.push_back(cyc - 1); end
      if (obs_er) begin src_q.push_back(1); gcyc_q.push_back(cyc - 1); end
    end
    t_valid = 0; e_valid = 0;
    if (src_q.size() < 6) expire("rr_grants");
    else begin
      for (int k = 0; k < 6; k++) chk("rr_order", src_q[k], k % 2);
      chk("rr_first_cycle", gcyc_q[0], 0);
      chk("rr_spacing", gcyc_q[1] - gcyc_q[0], 5);
    end
    repeat (6) tick();

    // Blink refresh alternates off/on, no ready pulses
    do_reset();
    blink_mask = 4'b0011; t_digits = 16'h1234; t_dp = 0; t_valid = 1;
    tick(); t_valid = 0;
    repeat (4) tick();
    cnt_ready = 0;
    for (int i = 0; i < 56; i++) begin
      tick();
      if (obs_tr || obs_er) cnt_ready++;
      if (obs_wr && obs_waddr == 4) ref_q.push_back(obs_wdata);
    end
    chk("blink_no_ready", cnt_ready, 0);
    if (ref_q.size() < 3) expire("blink_refresh");
    else begin
      chk("blink_ref0", ref_q[0], 32'h81820000);
      chk("blink_ref1", ref_q[1], 32'h81828384);
      chk("blink_ref2", ref_q[2], 32'h81820000);
    end

    // Sticky error, clear, and mismatch beating clear
    do_reset();
    corrupt = 1; t_digits = 16'h4321; t_valid = 1;
    wait_t_grant("err_grant1");
    repeat (4) tick();
    corrupt = 0;
    chk("err_set", err, 1);
    t_valid = 1;
    wait_t_grant("err_grant2");
    repeat (5) tick();
    chk("err_sticky", err, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("err_cleared", err, 0);
    corrupt = 1; err_clr = 1; t_valid = 1;
    wait_t_grant("err_grant3");
    repeat (4) tick();
    chk("err_beats_clr", err, 1);
    corrupt = 0; err_clr = 0;
    repeat (3) tick();

    // Reset in WR_STATIC: strobes drop at once, then silence
    do_reset();
    t_digits = 16'h7777; t_valid = 1;
    tick(); t_valid = 0;
    tick();
    #1 chk("pre_rst_wr", {wr, 28'(waddr)}, {1'b1, 28'h8});
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {wr, rd, waddr, raddr, busy, err, t_ready, e_ready}, 0);
    chk("rst_mid_wdata", wdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cnt_bus = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_wr) cnt_bus++;
    end
    chk("post_rst_silence", cnt_bus, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!t_valid && $urandom_range(0, 3) == 0) begin
        t_valid = 1; t_digits = 16'($urandom); t_dp = 4'($urandom); t_led = 8'($urandom);
      end
      if (!e_valid && $urandom_range(0, 3) == 0) begin
        e_valid = 1; e_frame = $urandom; e_led = 8'($urandom);
      end
      blink_mask = 4'($urandom);
      err_clr = ($urandom_range(0, 7) == 0);
      corrupt = ($urandom_range(0, 9) == 0);
      tick();
      if (obs_tr) t_valid = 0;
      if (obs_er) e_valid = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected one", cyc);
    $fatal(1);
  end
endmodule
